// File: rtl/disp_page_sched.sv
// Page-select sequencer and digit-scan timebase for the 8-digit TDM 7-segment driver.
// Optional macro PAGE_SKIP_EMPTY_EN adds page1_valid so an empty BR3 page is skipped.
module disp_page_sched #(
  parameter int SCAN_DIV    = 100000,
  parameter int DWELL_TICKS = 2000,
  parameter int N_DIGITS    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        btn_next,
  input  logic                        auto_en,
  input  logic                        freeze,
`ifdef PAGE_SKIP_EMPTY_EN
  input  logic                        page1_valid,
`endif
  output logic                        sel,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx,
  output logic                        scan_tick,
  output logic                        blank,
  output logic                        page_changed
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DWL_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam int DIG_W = $clog2(N_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [DWL_W-1:0] DWL_LAST = DWL_W'(DWELL_TICKS - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(N_DIGITS - 1);

  typedef enum logic [2:0] {
    PAGE0  = 3'd0,
    WAIT01 = 3'd1,
    BLANK1 = 3'd2,
    PAGE1  = 3'd3,
    WAIT10 = 3'd4,
    BLANK0 = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIG_W-1:0] digit_q, digit_d;
  logic [DWL_W-1:0] dwell_q, dwell_d;
  logic             btn_q;
  logic             sel_q, sel_d;
  logic             blank_q, blank_d;
  logic             changed_q, changed_d;

  logic tick;
  logic frame_end;
  logic in_page;
  logic btn_rise;
  logic auto_req;
  logic req;
  logic p1_ok;

`ifdef PAGE_SKIP_EMPTY_EN
  assign p1_ok = page1_valid;
`else
  assign p1_ok = 1'b1;
`endif

  // Prescaler and digit scan counter
  always_comb begin
    tick      = (cnt_q == CNT_LAST);
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    frame_end = tick && (digit_q == DIG_LAST);
    digit_d   = digit_q;
    if (tick) begin
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
    end
  end

  assign in_page  = (state_q == PAGE0) || (state_q == PAGE1);
  assign btn_rise = btn_next && !btn_q;

  // Dwell timer only runs while a page is being shown; leaving a page clears it
  always_comb begin
    dwell_d  = dwell_q;
    auto_req = 1'b0;
    if (!in_page || !auto_en) begin
      dwell_d = '0;
    end else if (!freeze && tick) begin
      if (dwell_q == DWL_LAST) begin
        dwell_d  = '0;
        auto_req = 1'b1;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  assign req = auto_req || btn_rise;

  always_comb begin
    state_d = state_q;
    case (state_q)
      PAGE0:  if (req && p1_ok) state_d = WAIT01;
      WAIT01: if (frame_end) state_d = BLANK1;
      BLANK1: begin
        if (!p1_ok) begin
          state_d = WAIT10;
        end else if (frame_end) begin
          state_d = PAGE1;
        end
      end
      PAGE1:  if (req || !p1_ok) state_d = WAIT10;
      WAIT10: if (frame_end) state_d = BLANK0;
      BLANK0: if (frame_end) state_d = PAGE0;
      default: state_d = PAGE0;
    endcase
  end

  // Outputs are decoded from the next state so they change on the transition edge
  always_comb begin
    sel_d     = (state_d == BLANK1) || (state_d == PAGE1) || (state_d == WAIT10);
    blank_d   = (state_d == BLANK1) || (state_d == BLANK0);
    changed_d = (sel_d != sel_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= PAGE0;
      cnt_q     <= '0;
      digit_q   <= '0;
      dwell_q   <= '0;
      btn_q     <= 1'b1;
      sel_q     <= 1'b0;
      blank_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      dwell_q   <= dwell_d;
      btn_q     <= btn_next;
      sel_q     <= sel_d;
      blank_q   <= blank_d;
      changed_q <= changed_d;
    end
  end

  assign sel          = sel_q;
  assign digit_idx    = digit_q;
  assign scan_tick    = tick;
  assign blank        = blank_q;
  assign page_changed = changed_q;

endmodule

// File: tb/tb_disp_page_sched.sv
// Directed bench for disp_page_sched with SCAN_DIV=4, DWELL_TICKS=3, N_DIGITS=8.
// Cycle k is the k-th clock period after reset release; outputs are sampled 1ns after each edge.
module tb_disp_page_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_next = 1'b0;
  logic       auto_en = 1'b0;
  logic       freeze = 1'b0;
`ifdef PAGE_SKIP_EMPTY_EN
  logic       page1_valid = 1'b1;
`endif
  logic       sel;
  logic [2:0] digit_idx;
  logic       scan_tick;
  logic       blank;
  logic       page_changed;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  disp_page_sched #(
    .SCAN_DIV   (4),
    .DWELL_TICKS(3),
    .N_DIGITS   (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_next    (btn_next),
    .auto_en     (auto_en),
    .freeze      (freeze),
`ifdef PAGE_SKIP_EMPTY_EN
    .page1_valid (page1_valid),
`endif
    .sel         (sel),
    .digit_idx   (digit_idx),
    .scan_tick   (scan_tick),
    .blank       (blank),
    .page_changed(page_changed)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 1;
  endtask

  task automatic test_reset();
    logic       exp_tick;
    logic [2:0] exp_dig;
    auto_en = 0; freeze = 0; btn_next = 0;
    do_reset(3);
    n_checks++;
    if ({sel, blank, page_changed, scan_tick} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outs cyc=%0d got sel/blank/pc/tick=%b exp=0000", cyc,
               {sel, blank, page_changed, scan_tick});
    end
    for (int c = 1; c <= 33; c++) begin
      run_to(c);
      exp_tick = (c % 4 == 0);
      exp_dig  = 3'(((c - 1) / 4) % 8);
      n_checks++;
      if (scan_tick !== exp_tick) begin
        n_fail++;
        $display("FAIL reset_tick cyc=%0d got=%b exp=%b", c, scan_tick, exp_tick);
      end
      n_checks++;
      if (digit_idx !== exp_dig) begin
        n_fail++;
        $display("FAIL reset_digit cyc=%0d got=%0d exp=%0d", c, digit_idx, exp_dig);
      end
    end
    $display("test_reset done at cycle %0d", cyc);
  endtask

  task automatic test_auto();
    logic es, eb, ep;
    auto_en = 1; freeze = 0; btn_next = 0;
    do_reset(3);
    for (int c = 1; c <= 161; c++) begin
      run_to(c);
      es = (c >= 33 && c <= 96) || (c >= 161);
      eb = (c >= 33 && c <= 64) || (c >= 97 && c <= 128) || (c >= 161);
      ep = (c == 33) || (c == 97) || (c == 161);
      n_checks++;
      if ({sel, blank, page_changed} !== {es, eb, ep}) begin
        n_fail++;
        $display("FAIL auto_rotate cyc=%0d got sel/blank/pc=%b exp=%b", c,
                 {sel, blank, page_changed}, {es, eb, ep});
      end
    end
    auto_en = 0;
    $display("test_auto done at cycle %0d", cyc);
  endtask

  task automatic test_manual();
    logic es, eb;
    auto_en = 0; freeze = 0; btn_next = 0;
    do_reset(3);
    for (int c = 1; c <= 200; c++) begin
      run_to(c);
      btn_next = (c == 10) || (c == 20);
      es = (c >= 33);
      eb = (c >= 33 && c <= 64);
      n_checks++;
      if ({sel, blank} !== {es, eb}) begin
        n_fail++;
        $display("FAIL manual_btn cyc=%0d got sel/blank=%b exp=%b", c, {sel, blank}, {es, eb});
      end
    end
    btn_next = 0;
    $display("test_manual done at cycle %0d", cyc);
  endtask

  task automatic test_btn_held();
    auto_en = 0; freeze = 0; btn_next = 1;
    do_reset(3);
    for (int c = 1; c <= 40; c++) begin
      run_to(c);
      if (c == 6) btn_next = 0;
      n_checks++;
      if ({sel, blank} !== 2'b00) begin
        n_fail++;
        $display("FAIL btn_held cyc=%0d got sel/blank=%b exp=00", c, {sel, blank});
      end
    end
    $display("test_btn_held done at cycle %0d", cyc);
  endtask

  task automatic test_coincident();
    logic es;
    auto_en = 0; freeze = 0; btn_next = 0;
    do_reset(3);
    for (int c = 1; c <= 66; c++) begin
      run_to(c);
      btn_next = (c == 32);
      es = (c >= 65);
      n_checks++;
      if (sel !== es) begin
        n_fail++;
        $display("FAIL coincident cyc=%0d got sel=%b exp=%b", c, sel, es);
      end
    end
    btn_next = 0;
    $display("test_coincident done at cycle %0d", cyc);
  endtask

  task automatic test_freeze();
    logic es;
    auto_en = 1; freeze = 1; btn_next = 0;
    do_reset(3);
    for (int c = 1; c <= 546; c++) begin
      run_to(c);
      if (c == 513) freeze = 0;
      es = (c >= 545);
      n_checks++;
      if (sel !== es) begin
        n_fail++;
        $display("FAIL freeze cyc=%0d got sel=%b exp=%b", c, sel, es);
      end
    end
    n_checks++;
    if (page_changed !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze_pc cyc=%0d got=%b exp=0", cyc, page_changed);
    end
    auto_en = 0;
    $display("test_freeze done at cycle %0d", cyc);
  endtask

  task automatic test_reset_mid();
    logic es, et;
    auto_en = 1; freeze = 0; btn_next = 0;
    do_reset(3);
    run_to(40);
    n_checks++;
    if ({sel, blank} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_pre cyc=%0d got sel/blank=%b exp=11", cyc, {sel, blank});
    end
    reset = 1;
    step();
    reset = 0;
    n_checks++;
    if ({sel, blank, page_changed, scan_tick, digit_idx} !== 7'b0000_000) begin
      n_fail++;
      $display("FAIL mid_reset cyc=%0d got sel/blank/pc/tick/dig=%b exp=0000000", cyc,
               {sel, blank, page_changed, scan_tick, digit_idx});
    end
    for (int c = 42; c <= 73; c++) begin
      run_to(c);
      et = ((c - 40) % 4 == 0);
      es = (c >= 73);
      n_checks++;
      if ({scan_tick, sel} !== {et, es}) begin
        n_fail++;
        $display("FAIL mid_resume cyc=%0d got tick/sel=%b exp=%b", c, {scan_tick, sel}, {et, es});
      end
    end
    auto_en = 0;
    $display("test_reset_mid done at cycle %0d", cyc);
  endtask

`ifdef PAGE_SKIP_EMPTY_EN
  task automatic test_skip_empty();
    logic es, eb;
    auto_en = 0; freeze = 0; btn_next = 0; page1_valid = 0;
    do_reset(3);
    for (int c = 1; c <= 130; c++) begin
      run_to(c);
      btn_next = (c == 5) || (c == 75);
      if (c == 70) page1_valid = 1;
      if (c == 100) page1_valid = 0;
      es = (c >= 97 && c <= 128);
      eb = (c >= 97 && c <= 100) || (c >= 129);
      n_checks++;
      if ({sel, blank} !== {es, eb}) begin
        n_fail++;
        $display("FAIL skip_empty cyc=%0d got sel/blank=%b exp=%b", c, {sel, blank}, {es, eb});
      end
    end
    btn_next = 0; page1_valid = 1;
    $display("test_skip_empty done at cycle %0d", cyc);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_auto();
    test_manual();
    test_btn_held();
    test_coincident();
    test_freeze();
    test_reset_mid();
`ifdef PAGE_SKIP_EMPTY_EN
    test_skip_empty();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
